hsv_core_flush_responder: RTL
=============================

// Module: hsv_core_flush_responder
// PURPOSE
//  Responder end of the core flush handshake (flush_req/flush_target/flush_ack) driven by the ctrlstatus FSM.
//  Halts fetch, kills in-flight pipeline stages, drains outstanding fetch-bus transactions, acks, then redirects
//  the fetch PC to flush_target and resumes. Sits between ctrlstatus and the fetch/pipeline stages.
// PARAMETERS
//  MAX_OUTSTANDING   4  max in-flight fetch-bus requests; counter width = $clog2(MAX_OUTSTANDING+1)
//  MIN_DRAIN_CYCLES  3  minimum cycles flush_o is held (pipeline depth ahead of commit), >=1
// PORTS
//  clk_core       in   1   core clock
//  rst_core_n     in   1   reset, synchronous, active-low
//  flush_req      in   1   flush request from ctrlstatus (4-phase, level)
//  flush_target   in   32  redirect PC (word); valid/stable whenever flush_req has been high >=1 cycle
//  flush_ack      out  1   flush acknowledge (4-phase, level)
//  flush_o        out  1   kill to all pipeline stages (invalidate valid bits)
//  fetch_halt     out  1   fetch must not issue new bus requests
//  mem_req_fire   in   1   fetch-bus request accepted this cycle
//  mem_rsp_fire   in   1   fetch-bus response returned this cycle
//  rsp_discard    out  1   fetch must drop the response returned this cycle
//  pc_load        out  1   one-cycle pulse: fetch PC <= pc_load_value
//  pc_load_value  out  32  redirect address (registered copy of flush_target)
// BEHAVIOUR
//  Reset (rst_core_n low at posedge): state=RUN, flush_ack=0, flush_o=0, fetch_halt=0, pc_load=0,
//   pc_load_value=0, outstanding=0, drain_cnt=0. Reset mid-flush abandons all; requester is reset alongside.
//  Outstanding counter: +1 on mem_req_fire, -1 on mem_rsp_fire, unchanged if both. Increment at
//   MAX_OUTSTANDING or decrement at 0 is illegal: assertion fires, value saturates.
//  States (registered, all outputs decoded from state + registers, no comb path req->ack):
//   RUN:     fetch_halt=0, flush_o=0, ack=0, rsp_discard=0. flush_req=1 -> DRAIN, drain_cnt<=MIN_DRAIN_CYCLES-1.
//   DRAIN:   fetch_halt=1, flush_o=1, rsp_discard=1. drain_cnt decrements to 0 and holds.
//            drain_cnt==0 && outstanding==0 (post-update value not required; use registered) -> ACK.
//            flush_req dropping in DRAIN is a protocol violation: assertion; block still completes to ACK.
//   ACK:     flush_ack=1, fetch_halt=1, flush_o=0, rsp_discard=1. pc_load_value<=flush_target every cycle
//            (target may be rewritten while req stays high, e.g. wait-for-irq then trap).
//            flush_req==0 -> RELEASE.
//   RELEASE: flush_ack=0, pc_load=1 (value = last flush_target captured in ACK), fetch_halt=1. Next -> RUN.
//            flush_req==1 in RELEASE -> DRAIN directly (back-to-back flush; pc_load still pulses).
//  Latency: req rise -> ack rise = max(MIN_DRAIN_CYCLES, drain of bus)+1 cycles; min 1+MIN_DRAIN_CYCLES.
//   req fall -> ack fall 1 cycle; ack fall -> first new fetch request possible 1 cycle (RUN).
//  mem_req_fire while fetch_halt=1 is legal only in the halt's first cycle (issue race); still counted.
//  Responses in DRAIN/ACK/RELEASE are discarded; none can return in RUN from pre-flush requests because
//   ACK requires outstanding==0.
//  flush_req held high indefinitely (ctrlstatus waiting for IRQ): remain in ACK, fetch halted, target tracked.
// STRUCTURE
//  hsv_core_pkg: add flush_state_t enum {FLUSH_RUN, FLUSH_DRAIN, FLUSH_ACK, FLUSH_RELEASE}; reuse word type.
//  Sub-module hsv_core_flush_outstanding_ctr: parametric up/down counter with saturation + assertions,
//   outputs count and is_zero. FSM, drain timer and target register stay in this module.
// TESTING
//  1 Idle flush: outstanding=0, req high, target=0x0000_1000 -> ack rises cycle 4 (MIN_DRAIN=3),
//    flush_o high cycles 1-3; req low -> ack low next cycle, pc_load pulse with 0x0000_1000.
//  2 Bus drain: 3 requests in flight, responses at +2,+5,+9 after req -> ack only after 3rd response,
//    all 3 responses have rsp_discard=1.
//  3 Simultaneous req_fire+rsp_fire with count 2 -> count stays 2; ack delayed until both later retire.
//  4 Target change in ACK: req held, target 0x100 then 0x200 -> pc_load_value=0x200 on release.
//  5 Back-to-back: req re-rises in RELEASE cycle -> DRAIN next, pc_load pulses once, second ack follows.
//  6 Reset asserted in DRAIN with count 2 -> next cycle state RUN, ack=0, count=0, all outputs at reset values.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// Shared core types: machine word width and the flush responder state encoding.
package hsv_core_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FLUSH_RUN     = 2'd0,
    FLUSH_DRAIN   = 2'd1,
    FLUSH_ACK     = 2'd2,
    FLUSH_RELEASE = 2'd3
  } flush_state_t;

endpackage

// File: rtl/hsv_core_flush_outstanding_ctr.sv
// Up/down counter of in-flight fetch-bus requests; saturates at 0 and MAX and flags illegal moves.
module hsv_core_flush_outstanding_ctr #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_core,
  input  logic             rst_core_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_zero
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_OUTSTANDING);

  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      count <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   if (count != MAX_V) count <= count + 1'b1;
        2'b01:   if (count != '0)    count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign is_zero = (count == '0);

  always_ff @(posedge clk_core) begin
    if (rst_core_n) begin
      assert (!(inc && !dec && count == MAX_V))
        else $error("outstanding counter overflow");
      assert (!(dec && !inc && count == '0))
        else $error("outstanding counter underflow");
    end
  end

endmodule

// File: rtl/hsv_core_flush_responder.sv
// Responder side of the core flush handshake: halt fetch, kill pipe, drain the bus, ack, redirect PC.
module hsv_core_flush_responder
  import hsv_core_pkg::*;
#(
  parameter int MAX_OUTSTANDING  = 4,
  parameter int MIN_DRAIN_CYCLES = 3
) (
  input  logic              clk_core,
  input  logic              rst_core_n,
  input  logic              flush_req,
  input  logic [WORD_W-1:0] flush_target,
  output logic              flush_ack,
  output logic              flush_o,
  output logic              fetch_halt,
  input  logic              mem_req_fire,
  input  logic              mem_rsp_fire,
  output logic              rsp_discard,
  output logic              pc_load,
  output logic [WORD_W-1:0] pc_load_value
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int DW    = (MIN_DRAIN_CYCLES > 1) ? $clog2(MIN_DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(MIN_DRAIN_CYCLES - 1);

  flush_state_t     state;
  logic [DW-1:0]    drain_cnt;
  logic [CNT_W-1:0] outstanding;
  logic             out_zero;

  hsv_core_flush_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_ctr (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .inc        (mem_req_fire),
    .dec        (mem_rsp_fire),
    .count      (outstanding),
    .is_zero    (out_zero)
  );

  // ACK waits on the registered count, so a response retiring this cycle is seen one cycle later.
  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      state         <= FLUSH_RUN;
      drain_cnt     <= '0;
      pc_load_value <= '0;
    end else begin
      case (state)
        FLUSH_RUN: begin
          if (flush_req) begin
            state     <= FLUSH_DRAIN;
            drain_cnt <= DRAIN_INIT;
          end
        end
        FLUSH_DRAIN: begin
          if (drain_cnt != '0)  drain_cnt <= drain_cnt - 1'b1;
          else if (out_zero)    state     <= FLUSH_ACK;
        end
        FLUSH_ACK: begin
          // Target can be rewritten while the requester parks in ACK (e.g. wfi then trap).
          pc_load_value <= flush_target;
          if (!flush_req) state <= FLUSH_RELEASE;
        end
        FLUSH_RELEASE: begin
          if (flush_req) begin
            state     <= FLUSH_DRAIN;
            drain_cnt <= DRAIN_INIT;
          end else begin
            state     <= FLUSH_RUN;
          end
        end
        default: state <= FLUSH_RUN;
      endcase
    end
  end

  assign flush_o     = (state == FLUSH_DRAIN);
  assign flush_ack   = (state == FLUSH_ACK);
  assign pc_load     = (state == FLUSH_RELEASE);
  assign fetch_halt  = (state != FLUSH_RUN);
  assign rsp_discard = (state != FLUSH_RUN);

  always_ff @(posedge clk_core) begin
    if (rst_core_n) begin
      assert (!(state == FLUSH_DRAIN && !flush_req))
        else $error("flush_req dropped before flush_ack");
      assert (int'(outstanding) <= MAX_OUTSTANDING)
        else $error("outstanding count out of range");
    end
  end

endmodule
